// File: rtl/green_centroid_ctrl.sv
// ---------------------------------------------------------------------------
// green_centroid_ctrl
//
// Frame-level controller behind the per-pixel green detector. Over one frame
// it accumulates the green-pixel count, the x/y coordinate sums and the
// bounding box. At frame end it runs one shared restoring divider twice to
// get the centroid (sx/cnt, then sy/cnt). It then holds the result on a
// valid/ready handshake until the consumer takes it.
//
// Ports:
//   PCLK         pixel clock, all state on the rising edge
//   reset_n      asynchronous active-low reset
//   frame_start  one-cycle pulse on the first cycle of a frame
//   frame_end    one-cycle pulse on the last cycle of a frame
//   e_pix        pixel strobe, qualifies eh_verde / x / y
//   eh_verde     detector flag for the current pixel
//   x, y         pixel coordinates (10 bits each)
//   res_valid    result available (held until res_ready)
//   res_ready    consumer accepts the result
//   found        count >= MIN_COUNT
//   cx, cy       centroid, truncated toward zero
//   count        green pixels in the frame
//   xmin..ymax   bounding box of the green pixels
//   busy         controller is dividing or holding a result
//   overrun      one-cycle pulse when a frame_start had to be dropped
// ---------------------------------------------------------------------------
module green_centroid_ctrl #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned MIN_COUNT = 64
) (
  input  logic        PCLK,
  input  logic        reset_n,
  input  logic        frame_start,
  input  logic        frame_end,
  input  logic        e_pix,
  input  logic        eh_verde,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        found,
  output logic [9:0]  cx,
  output logic [9:0]  cy,
  output logic [18:0] count,
  output logic [9:0]  xmin,
  output logic [9:0]  xmax,
  output logic [9:0]  ymin,
  output logic [9:0]  ymax,
  output logic        busy,
  output logic        overrun
);

  typedef enum logic [1:0] {IDLE, ACCUM, DIV, HOLD} state_t;

  state_t r_state, w_nextState;

  // Frame accumulators
  logic [18:0] r_cnt;
  logic [27:0] r_sx, r_sy;
  logic [9:0]  r_xmin, r_xmax, r_ymin, r_ymax;

  // Divider and snapshot registers
  logic [18:0] r_divisor;
  logic [27:0] r_rem, r_syHold;
  logic [9:0]  r_quot, r_qx;
  logic [4:0]  r_iter;
  logic [9:0]  r_snapXmin, r_snapXmax, r_snapYmin, r_snapYmax;

  // Result / status registers
  logic        r_resValid, r_found, r_busy, r_overrun;
  logic [9:0]  r_cx, r_cy, r_oXmin, r_oXmax, r_oYmin, r_oYmax;
  logic [18:0] r_count;

  logic        w_inWindow, w_accept, w_clearAcc, w_snapshot, w_belowMin, w_divDone;
  logic [18:0] w_cntNext;
  logic [27:0] w_sxNext, w_syNext;
  logic [9:0]  w_xminNext, w_xmaxNext, w_yminNext, w_ymaxNext;
  logic [3:0]  w_bit;
  logic [28:0] w_shifted, w_diff;
  logic        w_fits;
  logic [9:0]  w_quotNext;

  // Accumulator next values. These include a pixel that arrives together
  // with frame_end, so the snapshot sees the complete frame.
  assign w_inWindow = ({22'd0, x} < H_ACTIVE) && ({22'd0, y} < V_ACTIVE);
  assign w_accept   = (r_state == ACCUM) && e_pix && eh_verde && w_inWindow;
  assign w_cntNext  = r_cnt + {18'd0, w_accept};
  assign w_sxNext   = r_sx + (w_accept ? {18'd0, x} : 28'd0);
  assign w_syNext   = r_sy + (w_accept ? {18'd0, y} : 28'd0);
  assign w_xminNext = (w_accept && (x < r_xmin)) ? x : r_xmin;
  assign w_xmaxNext = (w_accept && (x > r_xmax)) ? x : r_xmax;
  assign w_yminNext = (w_accept && (y < r_ymin)) ? y : r_ymin;
  assign w_ymaxNext = (w_accept && (y > r_ymax)) ? y : r_ymax;
  assign w_belowMin = {13'd0, w_cntNext} < MIN_COUNT;

  // Iterations 0..9 produce sx/cnt bits 9..0 and iterations 10..19 produce
  // sy/cnt bits 9..0. The quotient is below 1024, so comparing against
  // divisor<<bit with the remainder kept unshifted is a valid restoring step.
  always_comb begin
    w_bit = 4'd0;
    if (r_iter < 5'd10) begin
      w_bit = 4'(5'd9 - r_iter);
    end else begin
      w_bit = 4'(5'd19 - r_iter);
    end
  end

  assign w_shifted  = {10'd0, r_divisor} << w_bit;
  assign w_diff     = {1'b0, r_rem} - w_shifted;
  assign w_fits     = ~w_diff[28];
  assign w_quotNext = r_quot | ({9'd0, w_fits} << w_bit);
  assign w_divDone  = (r_iter == 5'd19);

  // Next-state logic. A frame_start in ACCUM abandons the current frame and
  // takes priority over a coincident frame_end.
  always_comb begin
    w_nextState = r_state;
    w_clearAcc  = 1'b0;
    w_snapshot  = 1'b0;
    case (r_state)
      IDLE: begin
        if (frame_start) begin
          w_clearAcc  = 1'b1;
          w_nextState = ACCUM;
        end
      end
      ACCUM: begin
        if (frame_start) begin
          w_clearAcc = 1'b1;
        end else if (frame_end) begin
          w_snapshot  = 1'b1;
          w_nextState = w_belowMin ? HOLD : DIV;
        end
      end
      DIV: begin
        if (w_divDone) begin
          w_nextState = HOLD;
        end
      end
      HOLD: begin
        if (r_resValid && res_ready) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_ff @(posedge PCLK or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt  <= '0;
      r_sx   <= '0;
      r_sy   <= '0;
      r_xmin <= 10'd1023;
      r_xmax <= '0;
      r_ymin <= 10'd1023;
      r_ymax <= '0;
    end else if (w_clearAcc) begin
      r_cnt  <= '0;
      r_sx   <= '0;
      r_sy   <= '0;
      r_xmin <= 10'd1023;
      r_xmax <= '0;
      r_ymin <= 10'd1023;
      r_ymax <= '0;
    end else if (w_accept) begin
      r_cnt  <= w_cntNext;
      r_sx   <= w_sxNext;
      r_sy   <= w_syNext;
      r_xmin <= w_xminNext;
      r_xmax <= w_xmaxNext;
      r_ymin <= w_yminNext;
      r_ymax <= w_ymaxNext;
    end
  end

  // Divider datapath. At iteration 9 the x quotient is parked in r_qx and
  // the remainder is reloaded with the y sum for the second pass.
  always_ff @(posedge PCLK or negedge reset_n) begin
    if (!reset_n) begin
      r_divisor  <= '0;
      r_rem      <= '0;
      r_syHold   <= '0;
      r_quot     <= '0;
      r_qx       <= '0;
      r_iter     <= '0;
      r_snapXmin <= '0;
      r_snapXmax <= '0;
      r_snapYmin <= '0;
      r_snapYmax <= '0;
    end else if (w_snapshot && !w_belowMin) begin
      r_divisor  <= w_cntNext;
      r_rem      <= w_sxNext;
      r_syHold   <= w_syNext;
      r_quot     <= '0;
      r_iter     <= '0;
      r_snapXmin <= w_xminNext;
      r_snapXmax <= w_xmaxNext;
      r_snapYmin <= w_yminNext;
      r_snapYmax <= w_ymaxNext;
    end else if (r_state == DIV) begin
      r_iter <= r_iter + 5'd1;
      if (r_iter == 5'd9) begin
        r_qx   <= w_quotNext;
        r_rem  <= r_syHold;
        r_quot <= '0;
      end else begin
        r_quot <= w_quotNext;
        if (w_fits) begin
          r_rem <= w_diff[27:0];
        end
      end
    end
  end

  // Result registers change only when HOLD is entered. On the below-threshold
  // path, HOLD is entered straight from ACCUM, and res_valid rises one cycle
  // later from the HOLD state itself.
  always_ff @(posedge PCLK or negedge reset_n) begin
    if (!reset_n) begin
      r_resValid <= 1'b0;
      r_found    <= 1'b0;
      r_cx       <= '0;
      r_cy       <= '0;
      r_count    <= '0;
      r_oXmin    <= '0;
      r_oXmax    <= '0;
      r_oYmin    <= '0;
      r_oYmax    <= '0;
      r_busy     <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_busy    <= (w_nextState == DIV) || (w_nextState == HOLD);
      r_overrun <= frame_start && ((r_state == DIV) || (r_state == HOLD));
      if (w_snapshot && w_belowMin) begin
        r_found <= 1'b0;
        r_cx    <= '0;
        r_cy    <= '0;
        r_count <= w_cntNext;
        r_oXmin <= '0;
        r_oXmax <= '0;
        r_oYmin <= '0;
        r_oYmax <= '0;
      end else if ((r_state == DIV) && w_divDone) begin
        r_found <= 1'b1;
        r_cx    <= r_qx;
        r_cy    <= w_quotNext;
        r_count <= r_divisor;
        r_oXmin <= r_snapXmin;
        r_oXmax <= r_snapXmax;
        r_oYmin <= r_snapYmin;
        r_oYmax <= r_snapYmax;
      end
      if ((r_state == DIV) && w_divDone) begin
        r_resValid <= 1'b1;
      end else if (r_state == HOLD) begin
        r_resValid <= !(r_resValid && res_ready);
      end
    end
  end

  assign res_valid = r_resValid;
  assign found     = r_found;
  assign cx        = r_cx;
  assign cy        = r_cy;
  assign count     = r_count;
  assign xmin      = r_oXmin;
  assign xmax      = r_oXmax;
  assign ymin      = r_oYmin;
  assign ymax      = r_oYmax;
  assign busy      = r_busy;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_green_centroid_ctrl.sv
// ---------------------------------------------------------------------------
// tb_green_centroid_ctrl
//
// Two copies of the controller share one stimulus stream: dutA uses the
// default threshold (64) and dutB uses a threshold of 1, so one pixel already
// counts as found. The stimulus pushes hand-computed results into one queue
// per copy. Monitors pop and compare whenever res_valid rises, and they also
// check the latency measured from the frame_end edge.
// ---------------------------------------------------------------------------
module tb_green_centroid_ctrl;

  logic        pclk = 1'b0;
  logic        resetN = 1'b0;
  logic        frameStart = 1'b0, frameEnd = 1'b0, ePix = 1'b0, ehVerde = 1'b0;
  logic [9:0]  px = '0, py = '0;
  logic        rdyA = 1'b0;
  logic        rdyB = 1'b1;

  logic        validA, foundA, busyA, overrunA;
  logic [9:0]  cxA, cyA, xminA, xmaxA, yminA, ymaxA;
  logic [18:0] countA;
  logic        validB, foundB, busyB, overrunB;
  logic [9:0]  cxB, cyB, xminB, xmaxB, yminB, ymaxB;
  logic [18:0] countB;

  typedef struct {
    int found; int cx; int cy; int cnt;
    int xmin; int xmax; int ymin; int ymax;
    int lat; int tEdge;
  } expT;

  expT qA[$];
  expT qB[$];
  expT curA, curB;
  int  total = 0;
  int  bad = 0;
  int  edgeNum = 0;
  int  lastEnd = 0;
  logic prevA = 1'b0, prevB = 1'b0;

  green_centroid_ctrl dutA (
    .PCLK(pclk), .reset_n(resetN), .frame_start(frameStart), .frame_end(frameEnd),
    .e_pix(ePix), .eh_verde(ehVerde), .x(px), .y(py),
    .res_valid(validA), .res_ready(rdyA), .found(foundA), .cx(cxA), .cy(cyA),
    .count(countA), .xmin(xminA), .xmax(xmaxA), .ymin(yminA), .ymax(ymaxA),
    .busy(busyA), .overrun(overrunA)
  );

  green_centroid_ctrl #(.MIN_COUNT(1)) dutB (
    .PCLK(pclk), .reset_n(resetN), .frame_start(frameStart), .frame_end(frameEnd),
    .e_pix(ePix), .eh_verde(ehVerde), .x(px), .y(py),
    .res_valid(validB), .res_ready(rdyB), .found(foundB), .cx(cxB), .cy(cyB),
    .count(countB), .xmin(xminB), .xmax(xmaxB), .ymin(yminB), .ymax(ymaxB),
    .busy(busyB), .overrun(overrunB)
  );

  // 100 MHz-style pixel clock
  always #5 pclk = ~pclk;

  // Rising-edge counter used to measure result latency
  always @(posedge pclk) edgeNum++;

  // Safety net in case some bounded wait is itself broken
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 40000 cycles");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drives one cycle of inputs at the falling edge; sampled on the next rise
  task automatic applyStimulus(input int fs, input int fe, input int ep, input int gv,
                               input int xv, input int yv);
    @(negedge pclk);
    frameStart = (fs != 0);
    frameEnd   = (fe != 0);
    ePix       = (ep != 0);
    ehVerde    = (gv != 0);
    px         = 10'(xv);
    py         = 10'(yv);
    if (fe != 0) lastEnd = edgeNum + 1;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(0, 0, 0, 0, 0, 0);
  endtask

  task automatic pushExp(input int toB, input int f, input int ecx, input int ecy,
                         input int cnt, input int x0, input int x1, input int y0,
                         input int y1, input int lat);
    expT e;
    e.found = f; e.cx = ecx; e.cy = ecy; e.cnt = cnt;
    e.xmin = x0; e.xmax = x1; e.ymin = y0; e.ymax = y1;
    e.lat = lat; e.tEdge = lastEnd;
    if (toB != 0) qB.push_back(e);
    else qA.push_back(e);
  endtask

  task automatic checkResult(input string tag, input expT e, input int f, input int rcx,
                             input int rcy, input int cnt, input int x0, input int x1,
                             input int y0, input int y1);
    checkOutput({tag, ".found"}, f, e.found);
    checkOutput({tag, ".cx"}, rcx, e.cx);
    checkOutput({tag, ".cy"}, rcy, e.cy);
    checkOutput({tag, ".count"}, cnt, e.cnt);
    checkOutput({tag, ".xmin"}, x0, e.xmin);
    checkOutput({tag, ".xmax"}, x1, e.xmax);
    checkOutput({tag, ".ymin"}, y0, e.ymin);
    checkOutput({tag, ".ymax"}, y1, e.ymax);
    checkOutput({tag, ".latency"}, edgeNum - e.tEdge, e.lat);
  endtask

  // Monitor for dutA: a new result is a rising res_valid
  always begin
    @(posedge pclk);
    #1;
    if (validA && !prevA) begin
      if (qA.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL A.unexpected: got a result, expected none");
      end else begin
        curA = qA.pop_front();
        checkResult("A", curA, int'(foundA), int'(cxA), int'(cyA), int'(countA),
                    int'(xminA), int'(xmaxA), int'(yminA), int'(ymaxA));
      end
    end
    prevA = validA;
  end

  // Monitor for dutB
  always begin
    @(posedge pclk);
    #1;
    if (validB && !prevB) begin
      if (qB.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL B.unexpected: got a result, expected none");
      end else begin
        curB = qB.pop_front();
        checkResult("B", curB, int'(foundB), int'(cxB), int'(cyB), int'(countB),
                    int'(xminB), int'(xmaxB), int'(yminB), int'(ymaxB));
      end
    end
    prevB = validB;
  end

  task automatic waitDone(input int maxCycles);
    int n = 0;
    while ((busyA || busyB || validA || validB || qA.size() != 0 || qB.size() != 0)
           && n < maxCycles) begin
      idle(1);
      n++;
    end
    checkOutput("doneInTime", int'(n < maxCycles), 1);
  endtask

  task automatic waitValidA(input int maxCycles);
    int n = 0;
    while (!validA && n < maxCycles) begin
      idle(1);
      n++;
    end
    checkOutput("A.validArrived", int'(validA), 1);
  endtask

  initial begin
    $display("[TB] start");
    idle(2);

    // Reset values while reset_n is held low
    checkOutput("rst.A.valid", int'(validA), 0);
    checkOutput("rst.A.found", int'(foundA), 0);
    checkOutput("rst.A.count", int'(countA), 0);
    checkOutput("rst.A.cx", int'(cxA), 0);
    checkOutput("rst.A.xmin", int'(xminA), 0);
    checkOutput("rst.A.ymin", int'(yminA), 0);
    checkOutput("rst.A.busy", int'(busyA), 0);
    checkOutput("rst.A.overrun", int'(overrunA), 0);
    checkOutput("rst.B.valid", int'(validB), 0);
    resetN = 1'b1;
    idle(2);
    rdyA = 1'b1;

    // Single pixel at (100,50): below threshold on A, found on B
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 1, 100, 50);
    applyStimulus(0, 1, 0, 0, 0, 0);
    pushExp(0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    pushExp(1, 1, 100, 50, 1, 100, 100, 50, 50, 20);
    idle(1);
    waitDone(60);

    // Rectangle x 200..219, y 300..309; last pixel arrives with frame_end
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 1, 700, 300);
    applyStimulus(0, 0, 1, 1, 210, 480);
    applyStimulus(0, 0, 1, 0, 5, 5);
    applyStimulus(0, 0, 0, 1, 5, 5);
    for (int yy = 300; yy <= 309; yy++) begin
      for (int xx = 200; xx <= 219; xx++) begin
        applyStimulus(0, int'(yy == 309 && xx == 219), 1, 1, xx, yy);
      end
    end
    pushExp(0, 1, 209, 304, 200, 200, 219, 300, 309, 20);
    pushExp(1, 1, 209, 304, 200, 200, 219, 300, 309, 20);
    idle(1);
    waitDone(60);

    // Ten pixels: below threshold on A, found on B
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 1, 700, 5);
    for (int i = 0; i < 10; i++) applyStimulus(0, int'(i == 9), 1, 1, 10 + i, 5);
    pushExp(0, 0, 0, 0, 10, 0, 0, 0, 0, 1);
    pushExp(1, 1, 14, 5, 10, 10, 19, 5, 5, 20);
    idle(1);
    waitDone(60);

    // Backpressure: 64 pixels x 300..363 at y 100, consumer not ready
    rdyA = 1'b0;
    applyStimulus(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 64; i++) applyStimulus(0, int'(i == 63), 1, 1, 300 + i, 100);
    pushExp(0, 1, 331, 100, 64, 300, 363, 100, 100, 20);
    pushExp(1, 1, 331, 100, 64, 300, 363, 100, 100, 20);
    idle(1);
    waitValidA(40);
    for (int c = 0; c < 50; c++) begin
      idle(1);
      checkOutput("hold.valid", int'(validA), 1);
      checkOutput("hold.cx", int'(cxA), 331);
      checkOutput("hold.cy", int'(cyA), 100);
      checkOutput("hold.count", int'(countA), 64);
    end

    // Frame during HOLD: dropped by A, accepted by idle B
    applyStimulus(1, 0, 0, 0, 0, 0);
    idle(1);
    checkOutput("ovr.high", int'(overrunA), 1);
    checkOutput("ovr.B", int'(overrunB), 0);
    applyStimulus(0, 0, 1, 1, 1, 1);
    checkOutput("ovr.low", int'(overrunA), 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, int'(i == 3), 1, 1, 1, 1);
    pushExp(1, 1, 1, 1, 5, 1, 1, 1, 1, 20);
    idle(26);
    checkOutput("hold.validStill", int'(validA), 1);
    checkOutput("hold.countStill", int'(countA), 64);
    checkOutput("B.idleAgain", int'(busyB), 0);

    // Handshake in the same cycle as a frame_start: frame dropped, A goes idle
    applyStimulus(1, 0, 0, 0, 0, 0);
    rdyA = 1'b1;
    idle(1);
    checkOutput("hs.validDrop", int'(validA), 0);
    checkOutput("hs.overrun", int'(overrunA), 1);
    checkOutput("hs.busy", int'(busyA), 0);
    idle(1);
    checkOutput("hs.overrunLow", int'(overrunA), 0);

    // Abandon: 30 pixels, restart, then 100 pixels x 50..149 at y 60
    applyStimulus(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 30; i++) applyStimulus(0, 0, 1, 1, 400 + i, 200);
    applyStimulus(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 100; i++) applyStimulus(0, int'(i == 99), 1, 1, 50 + i, 60);
    pushExp(0, 1, 99, 60, 100, 50, 149, 60, 60, 20);
    pushExp(1, 1, 99, 60, 100, 50, 149, 60, 60, 20);
    idle(1);
    waitDone(60);

    // Reset during division (7 iterations done); this result is never produced
    applyStimulus(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 64; i++) applyStimulus(0, int'(i == 63), 1, 1, 500 + i, 400);
    idle(1);
    checkOutput("div.busy", int'(busyA), 1);
    repeat (7) @(posedge pclk);
    #1;
    resetN = 1'b0;
    #1;
    checkOutput("rstDiv.valid", int'(validA), 0);
    checkOutput("rstDiv.busy", int'(busyA), 0);
    checkOutput("rstDiv.count", int'(countA), 0);
    checkOutput("rstDiv.cx", int'(cxA), 0);
    checkOutput("rstDiv.cy", int'(cyA), 0);
    checkOutput("rstDiv.xmax", int'(xmaxA), 0);
    checkOutput("rstDiv.found", int'(foundA), 0);
    checkOutput("rstDiv.B.busy", int'(busyB), 0);
    idle(2);
    resetN = 1'b1;
    idle(2);

    // Boundary frame after reset: x 0..69 and 639 on the last line, edges excluded
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 1, 640, 0);
    applyStimulus(0, 0, 1, 1, 0, 480);
    for (int i = 0; i < 70; i++) applyStimulus(0, 0, 1, 1, i, 479);
    applyStimulus(0, 1, 1, 1, 639, 479);
    pushExp(0, 1, 43, 479, 71, 0, 639, 479, 479, 20);
    pushExp(1, 1, 43, 479, 71, 0, 639, 479, 479, 20);
    idle(1);
    waitDone(60);

    idle(5);
    checkOutput("qA.empty", qA.size(), 0);
    checkOutput("qB.empty", qB.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
